seg7_scan_mux: RTL



---
 rtl/seg7_scan_mux.sv | 94 +++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: scans eight active-low digit patterns onto a common-anode display with a blanking guard per slot.
// Optional macro SEG7_SCAN_SNAPSHOT_EN latches all digits once per frame so a frame never mixes input states.
module seg7_scan_mux #(
  parameter int CLK_HZ       = 50000000,
  parameter int SCAN_HZ      = 1000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] led0,
  input  logic [6:0] led1,
  input  logic [6:0] led2,
  input  logic [6:0] led3,
  input  logic [6:0] led4,
  input  logic [6:0] led5,
  input  logic [6:0] led6,
  input  logic [6:0] led7,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic [2:0] digit_idx,
  output logic       frame_tick
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] GLAST = PW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam bit HAS_G = GUARD_CYCLES > 0;
  if (DIV < 2 || GUARD_CYCLES >= DIV || GUARD_CYCLES < 0) begin : g_bad_cfg
    $fatal(1, "seg7_scan_mux: need DIV>=2 and 0<=GUARD_CYCLES<DIV");
  end
  typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [2:0] idx_n;
  logic tick_n;
  logic [6:0] pat, seg_n;
  logic [7:0] an_n;
  logic [6:0] live [8];
  assign live = '{led0, led1, led2, led3, led4, led5, led6, led7};
  always_comb begin
    state_n = state;
    pre_n = pre;
    idx_n = digit_idx;
    tick_n = 1'b0;
    if (!en) begin
      state_n = IDLE;
      pre_n = '0;
      idx_n = '0;
    end else if (state == IDLE) begin
      state_n = HAS_G ? GUARD : DRIVE;
      pre_n = '0;
      idx_n = '0;
    end else if (pre == LAST) begin
      state_n = HAS_G ? GUARD : DRIVE;
      pre_n = '0;
      idx_n = digit_idx + 3'd1;
      tick_n = digit_idx == 3'd7;
    end else begin
      state_n = (state == GUARD && pre == GLAST) ? DRIVE : state;
      pre_n = pre + PW'(1);
    end
  end
`ifdef SEG7_SCAN_SNAPSHOT_EN
  logic [6:0] shadow [8];
  logic load;
  // the frame's first slot both captures the inputs and displays the captured digit 0
  assign load = state_n != IDLE && pre_n == '0 && idx_n == 3'd0;
  assign pat = load ? live[idx_n] : shadow[idx_n];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) shadow <= '{default: 7'h7F};
    else if (load) shadow <= live;
`else
  assign pat = live[idx_n];
`endif
  assign seg_n = (state_n == IDLE) ? 7'h7F : pat;
  assign an_n = (state_n == DRIVE) ? ~(8'b1 << idx_n) : 8'hFF;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pre <= '0;
      digit_idx <= '0;
      frame_tick <= 1'b0;
      seg <= 7'h7F;
      an <= 8'hFF;
    end else begin
      state <= state_n;
      pre <= pre_n;
      digit_idx <= idx_n;
      frame_tick <= tick_n;
      seg <= seg_n;
      an <= an_n;
    end
endmodule
